// File: rtl/stream_xbar_pkg.sv
// Shared types and default widths for the stream crossbar/arbiter family.
package stream_xbar_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_T_DATA_WIDTH = 8;
  localparam int DEF_S_DATA_COUNT = 2;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer: registered outputs, full throughput, in_ready is
// "not full" and never depends combinationally on out_ready.
module stream_skid_buf
  import stream_xbar_pkg::*;
#(
  parameter int DATA_W = DEF_T_DATA_WIDTH + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [DATA_W-1:0] data_p0;
  logic              vld_p0;
  logic [DATA_W-1:0] skid_data_p0;
  logic              skid_vld_p0;

  assign in_ready  = !skid_vld_p0;
  assign out_data  = data_p0;
  assign out_valid = vld_p0;

  // Stage p0: output register, refilled from the skid entry before new input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0      <= 1'b0;
      data_p0     <= '0;
      skid_vld_p0 <= 1'b0;
    end else if (out_ready || !vld_p0) begin
      if (skid_vld_p0) begin
        data_p0     <= skid_data_p0;
        vld_p0      <= 1'b1;
        skid_vld_p0 <= 1'b0;
      end else begin
        vld_p0 <= in_valid;
        if (in_valid) data_p0 <= in_data;
      end
    end else if (in_valid && !skid_vld_p0) begin
      skid_data_p0 <= in_data;
      skid_vld_p0  <= 1'b1;
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-level round-robin N:1 stream arbiter. Define STREAM_RR_ARB_OUT_REG_EN
// to register all m_* outputs through a skid buffer (1-cycle latency).
module stream_rr_arbiter
  import stream_xbar_pkg::*;
#(
  parameter int T_DATA_WIDTH = DEF_T_DATA_WIDTH,
  parameter int S_DATA_COUNT = DEF_S_DATA_COUNT,
  parameter int T_ID_WIDTH   = $clog2(S_DATA_COUNT)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [S_DATA_COUNT-1:0]                   s_valid_i,
  input  logic [S_DATA_COUNT-1:0]                   s_last_i,
  output logic [S_DATA_COUNT-1:0]                   s_ready_o,
  output logic [T_DATA_WIDTH-1:0]                   m_data_o,
  output logic                                      m_valid_o,
  output logic                                      m_last_o,
  output logic [T_ID_WIDTH-1:0]                     m_id_o,
  input  logic                                      m_ready_i
);

  localparam int PKT_W = T_DATA_WIDTH + T_ID_WIDTH + 1;

  arb_state_t            state;
  logic [T_ID_WIDTH-1:0] grant;
  logic [T_ID_WIDTH-1:0] rr_ptr;
  logic                  busy;
  logic                  src_valid;
  logic                  src_xfer;
  logic                  stage_ready;
  logic [PKT_W-1:0]      stage_pkt;

  // First requester strictly after ptr, wrapping; ptr itself is checked last.
  function automatic logic [T_ID_WIDTH-1:0] rr_pick(
    input logic [T_ID_WIDTH-1:0]   ptr,
    input logic [S_DATA_COUNT-1:0] req
  );
    logic [T_ID_WIDTH-1:0] pick;
    logic [T_ID_WIDTH-1:0] idx_t;
    logic                  found;
    int                    idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= S_DATA_COUNT; i++) begin
      idx = int'(ptr) + i;
      if (idx >= S_DATA_COUNT) idx -= S_DATA_COUNT;
      idx_t = T_ID_WIDTH'(idx);
      if (!found && req[idx_t]) begin
        pick  = idx_t;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign busy      = (state == ARB_BUSY);
  assign src_valid = busy && s_valid_i[grant];
  assign src_xfer  = src_valid && stage_ready;
  assign stage_pkt = {s_last_i[grant], grant, s_data_i[grant]};

  always_comb begin
    s_ready_o = '0;
    if (busy) s_ready_o[grant] = stage_ready;
  end

  // Grant is held for the whole packet; a valid gap never releases it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ARB_IDLE;
      grant  <= '0;
      rr_ptr <= T_ID_WIDTH'(S_DATA_COUNT - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|s_valid_i) begin
            grant <= rr_pick(rr_ptr, s_valid_i);
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (src_xfer && s_last_i[grant]) begin
            rr_ptr <= grant;
            state  <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef STREAM_RR_ARB_OUT_REG_EN
  logic [PKT_W-1:0] out_pkt;

  stream_skid_buf #(
    .DATA_W(PKT_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (stage_pkt),
    .in_valid (src_valid),
    .in_ready (stage_ready),
    .out_data (out_pkt),
    .out_valid(m_valid_o),
    .out_ready(m_ready_i)
  );

  assign {m_last_o, m_id_o, m_data_o} = out_pkt;
`else
  assign stage_ready = m_ready_i;
  assign m_valid_o   = src_valid;
  assign {m_last_o, m_id_o, m_data_o} = busy ? stage_pkt : '0;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: a 2-source and a 4-source instance.
module tb_stream_rr_arbiter;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk;
  logic rst_n;

  logic [1:0][7:0] s_data2;
  logic [1:0]      s_valid2, s_last2, s_ready2;
  logic [7:0]      m_data2;
  logic            m_valid2, m_last2, m_ready2;
  logic [0:0]      m_id2;

  logic [3:0][7:0] s_data4;
  logic [3:0]      s_valid4, s_last4, s_ready4;
  logic [7:0]      m_data4;
  logic            m_valid4, m_last4, m_ready4;
  logic [1:0]      m_id4;

  stream_rr_arbiter #(.T_DATA_WIDTH(8), .S_DATA_COUNT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_data_i(s_data2), .s_valid_i(s_valid2),
    .s_last_i(s_last2), .s_ready_o(s_ready2), .m_data_o(m_data2),
    .m_valid_o(m_valid2), .m_last_o(m_last2), .m_id_o(m_id2), .m_ready_i(m_ready2)
  );

  stream_rr_arbiter #(.T_DATA_WIDTH(8), .S_DATA_COUNT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .s_data_i(s_data4), .s_valid_i(s_valid4),
    .s_last_i(s_last4), .s_ready_o(s_ready4), .m_data_o(m_data4),
    .m_valid_o(m_valid4), .m_last_o(m_last4), .m_id_o(m_id4), .m_ready_i(m_ready4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Per-source beat storage and expected output order
  logic [7:0] sd[4][64];
  logic       sl[4][64];
  int         hd[4];
  int         tl[4];
  beat_t      exp_q[$];

  int         cyc = 0;
  logic       use4 = 1'b0;
  logic       all_valid = 1'b0;
  logic [3:0] hold = 4'b0;
  int         rdy_mode = 0;
  logic       chk_gap = 1'b0;
  logic       have_prev = 1'b0;
  logic       prev_last = 1'b0;
  int         prev_cyc = 0;
  logic       stall_prev = 1'b0;
  logic [10:0] stall_beat = '0;
  logic [3:0] drv_v;

  logic       ov, ol, mr;
  logic [1:0] oid;
  logic [7:0] od;
  logic [3:0] sr;

  task automatic clear_src();
    for (int s = 0; s < 4; s++) begin
      hd[s] = 0;
      tl[s] = 0;
    end
  endtask

  function automatic logic src_pending();
    logic p;
    p = 1'b0;
    for (int s = 0; s < 4; s++) if (hd[s] != tl[s]) p = 1'b1;
    return p;
  endfunction

  task automatic load_pkt(input int src, input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      sd[src][tl[src]] = base + 8'(i);
      sl[src][tl[src]] = (i == len - 1);
      tl[src]++;
    end
  endtask

  task automatic expect_pkt(input logic [1:0] id, input logic [7:0] base, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.id   = id;
      b.data = base + 8'(i);
      b.last = (i == len - 1);
      exp_q.push_back(b);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit later, score and advance sources.
  task automatic cycle();
    logic  r;
    beat_t e;
    @(negedge clk);
    cyc++;
    r = (rdy_mode == 0) ? 1'b1 : cyc[0];
    m_ready2 = use4 ? 1'b1 : r;
    m_ready4 = use4 ? r : 1'b1;
    for (int s = 0; s < 4; s++) begin
      drv_v[s]    = all_valid || (hd[s] != tl[s] && !hold[s]);
      s_valid4[s] = drv_v[s] && (all_valid || use4);
      s_data4[s]  = all_valid ? 8'hEE : sd[s][hd[s]];
      s_last4[s]  = all_valid ? 1'b0 : sl[s][hd[s]];
    end
    for (int s = 0; s < 2; s++) begin
      s_valid2[s] = drv_v[s] && (all_valid || !use4);
      s_data2[s]  = all_valid ? 8'hEE : sd[s][hd[s]];
      s_last2[s]  = all_valid ? 1'b0 : sl[s][hd[s]];
    end
    #1;
    if (use4) begin
      ov = m_valid4; ol = m_last4; oid = m_id4; od = m_data4; mr = m_ready4; sr = s_ready4;
    end else begin
      ov = m_valid2; ol = m_last2; oid = {1'b0, m_id2}; od = m_data2; mr = m_ready2;
      sr = {2'b00, s_ready2};
    end
    if (stall_prev && hold == 4'b0) begin
      chk("stall_valid", 32'(ov), 32'd1);
      chk("stall_beat", 32'({oid, od, ol}), 32'(stall_beat));
    end
    stall_prev = ov && !mr;
    stall_beat = {oid, od, ol};
    if (ov && mr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {oid, od, 7'b0, ol}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_id", 32'(oid), 32'(e.id));
        chk("out_data", 32'(od), 32'(e.data));
        chk("out_last", 32'(ol), 32'(e.last));
        if (chk_gap && have_prev) chk("beat_gap", cyc - prev_cyc, prev_last ? 2 : 1);
        have_prev = 1'b1;
        prev_last = ol;
        prev_cyc  = cyc;
      end
    end
    if (!all_valid)
      for (int s = 0; s < 4; s++) if (drv_v[s] && sr[s]) hd[s]++;
  endtask

  task automatic drain(input int max);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || src_pending()) && k < max) begin
      cycle();
      k++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (3) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_src();
    exp_q.delete();
    hold = 4'b0; rdy_mode = 0; all_valid = 1'b0;
    chk_gap = 1'b0; have_prev = 1'b0; stall_prev = 1'b0;
    repeat (2) cycle();
    chk("rst_m_valid", 32'(ov), 32'd0);
    chk("rst_s_ready", 32'(sr), 32'd0);
    chk("rst_m_beat", 32'({oid, od, ol}), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d beats outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_src();
    m_ready2 = 1'b1; m_ready4 = 1'b1;
    s_valid2 = '0; s_valid4 = '0; s_last2 = '0; s_last4 = '0; s_data2 = '0; s_data4 = '0;

    // Reset held 3 cycles with every source valid, then the cycle after release
    all_valid = 1'b1;
    repeat (3) begin
      cycle();
      chk("rsthold_ready2", 32'(s_ready2), 32'd0);
      chk("rsthold_valid2", 32'(m_valid2), 32'd0);
      chk("rsthold_ready4", 32'(s_ready4), 32'd0);
      chk("rsthold_valid4", 32'(m_valid4), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("release_ready2", 32'(s_ready2), 32'd0);
    chk("release_valid2", 32'(m_valid2), 32'd0);
    chk("release_ready4", 32'(s_ready4), 32'd0);
    chk("release_valid4", 32'(m_valid4), 32'd0);

    // Round robin between two continuously busy sources, one bubble per packet
    use4 = 1'b0;
    do_reset();
    load_pkt(0, 8'h10, 3); load_pkt(0, 8'h10, 3);
    load_pkt(1, 8'h20, 3); load_pkt(1, 8'h20, 3);
    expect_pkt(0, 8'h10, 3); expect_pkt(1, 8'h20, 3);
    expect_pkt(0, 8'h10, 3); expect_pkt(1, 8'h20, 3);
    chk_gap = 1'b1;
    drain(200);

    // Backpressure: m_ready toggles every cycle
    do_reset();
    rdy_mode = 1;
    load_pkt(0, 8'h30, 4); load_pkt(1, 8'h38, 2);
    expect_pkt(0, 8'h30, 4); expect_pkt(1, 8'h38, 2);
    drain(200);

    // Packet lock: src0 pauses mid-packet while src1 waits
    do_reset();
    load_pkt(0, 8'h40, 5); load_pkt(1, 8'h50, 2);
    expect_pkt(0, 8'h40, 5); expect_pkt(1, 8'h50, 2);
    for (int k = 0; k < 50 && hd[0] < 2; k++) cycle();
    chk("lock_src0_progress", hd[0], 2);
    hold = 4'b0001;
    repeat (2) begin
      cycle();
      chk("lock_src1_ready", 32'(sr[1]), 32'd0);
      chk("lock_id", 32'(oid), 32'd0);
    end
    hold = 4'b0000;
    drain(200);

    // Wrap on four sources: src3 alone (regranted), then src1, then src0+src2
    use4 = 1'b1;
    do_reset();
    chk_gap = 1'b1;
    load_pkt(3, 8'h63, 1); load_pkt(3, 8'h64, 1);
    expect_pkt(3, 8'h63, 1); expect_pkt(3, 8'h64, 1);
    drain(100);
    have_prev = 1'b0;
    load_pkt(1, 8'h71, 1);
    expect_pkt(1, 8'h71, 1);
    drain(100);
    have_prev = 1'b0;
    load_pkt(0, 8'h80, 1); load_pkt(2, 8'h82, 1);
    expect_pkt(2, 8'h82, 1); expect_pkt(0, 8'h80, 1);
    drain(100);

    // Reset in the middle of a src1 packet; src0 must win afterwards
    use4 = 1'b0;
    do_reset();
    load_pkt(0, 8'h90, 2);
    expect_pkt(0, 8'h90, 2);
    drain(100);
    load_pkt(1, 8'hA0, 5);
    expect_pkt(1, 8'hA0, 5);
    for (int k = 0; k < 50 && exp_q.size() > 3; k++) cycle();
    chk("midrst_progress", exp_q.size(), 3);
    rst_n = 1'b0;
    clear_src();
    exp_q.delete();
    cycle();
    chk("midrst_m_valid", 32'(ov), 32'd0);
    chk("midrst_s_ready", 32'(sr), 32'd0);
    rst_n = 1'b1;
    load_pkt(0, 8'hB0, 2); load_pkt(1, 8'hC0, 1);
    expect_pkt(0, 8'hB0, 2); expect_pkt(1, 8'hC0, 1);
    drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
